// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one recoded digit of x is retired per clock
// into a 2*WIDTH+2 bit accumulator, with a start/ready/busy/done handshake.
module booth_mult_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int AW     = 2*WIDTH + 2;   // accumulator / partial-product width
   localparam int XW     = WIDTH + 3;     // extended multiplier plus the implicit 0 below the LSB
   localparam int DIGITS = WIDTH/2 + 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t              state;
   logic [XW-1:0]       x_sh;      // multiplier, shifted right two bits per digit
   logic [AW-1:0]       y_sh;      // multiplicand, pre-weighted by 4^i for the current digit
   logic [AW-1:0]       acc;
   logic [CNT_W-1:0]    cnt;

   logic [XW-1:0]       x_ext;
   logic [AW-1:0]       y_ext;
   logic [AW-1:0]       pp;
   logic                accept;

   // In signed mode the two extra top bits of x equal its sign, so the last
   // digit always recodes to 0 and latency is identical in both modes.
   assign x_ext  = {{2{is_signed & x[WIDTH-1]}}, x, 1'b0};
   assign y_ext  = {{(AW-WIDTH){is_signed & y[WIDTH-1]}}, y};
   assign accept = start & ready;

   always_comb begin
      // NOTE: pp gets a default before the case so no path leaves it unassigned (no latch).
      pp = '0;
      case (x_sh[2:0])
         3'b001, 3'b010: pp = y_sh;
         3'b011:         pp = y_sh << 1;
         3'b100:         pp = -(y_sh << 1);
         3'b101, 3'b110: pp = -y_sh;
         default:        pp = '0;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register sees
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: datapath registers are reset as well so an aborted run leaves no stale partial sum.
         state   <= IDLE;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         acc     <= '0;
         cnt     <= '0;
         x_sh    <= '0;
         y_sh    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= RUN;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end
            end

            RUN: begin
               acc  <= acc + pp;
               x_sh <= x_sh >> 2;
               y_sh <= y_sh << 2;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST_DIGIT) begin
                  state <= FIN;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end
            end

            FIN: begin
               product <= acc[2*WIDTH-1:0];
               done    <= 1'b1;
               if (accept) begin
                  state <= RUN;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase

         // Operand capture is shared by IDLE and FIN (back-to-back start).
         if (accept) begin
            x_sh <= x_ext;
            y_sh <= y_ext;
            acc  <= '0;
            cnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=8 (directed + random) and WIDTH=16 (random),
// checked against plain integer multiplication.
module tb_booth_mult_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start8 = 1'b0, is8 = 1'b0;
   logic [7:0]  x8 = '0, y8 = '0;
   logic        ready8, busy8, done8;
   logic [15:0] prod8;

   logic        start16 = 1'b0, is16 = 1'b0;
   logic [15:0] x16 = '0, y16 = '0;
   logic        ready16, busy16, done16;
   logic [31:0] prod16;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [63:0] prod;
      int          cyc;
   } exp_t;

   exp_t sb8[$];
   exp_t sb16[$];

   booth_mult_seq #(.WIDTH(8), .CNT_W(4)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .is_signed(is8), .x(x8), .y(y8),
      .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
   );

   booth_mult_seq #(.WIDTH(16), .CNT_W(4)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .is_signed(is16), .x(x16), .y(y16),
      .ready(ready16), .busy(busy16), .done(done16), .product(prod16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: interpret operands per mode and multiply as integers, keep 2*w bits.
   function automatic logic [63:0] ref_mul(input int w, input logic s,
                                          input logic [63:0] a, input logic [63:0] b);
      longint sa, sb, p;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      p = sa * sb;
      return 64'(p) & ((64'd1 << (2*w)) - 64'd1);
   endfunction

   // Monitor: pops the scoreboards whenever a done pulse is seen.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && done8) begin
         check("done8_expected", 64'(sb8.size() != 0), 64'd1);
         if (sb8.size() != 0) begin
            e = sb8.pop_front();
            check("prod8", 64'(prod8), e.prod);
            check("lat8", 64'(cyc - e.cyc), 64'd6);
         end
      end
      if (!rst && done16) begin
         check("done16_expected", 64'(sb16.size() != 0), 64'd1);
         if (sb16.size() != 0) begin
            e = sb16.pop_front();
            check("prod16", 64'(prod16), e.prod);
            check("lat16", 64'(cyc - e.cyc), 64'd10);
         end
      end
   end

   task automatic wait_ready8();
      int n = 0;
      while (!ready8 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("ready8_timeout", 64'(n), 64'd0);
   endtask

   task automatic wait_ready16();
      int n = 0;
      while (!ready16 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("ready16_timeout", 64'(n), 64'd0);
   endtask

   // Called at a negedge; the start is sampled at the following posedge.
   task automatic go8(input logic s, input logic [7:0] xv, input logic [7:0] yv);
      wait_ready8();
      start8 = 1'b1; is8 = s; x8 = xv; y8 = yv;
      sb8.push_back('{ref_mul(8, s, 64'(xv), 64'(yv)), cyc + 1});
      @(negedge clk);
      start8 = 1'b0; is8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
   endtask

   task automatic go16(input logic s, input logic [15:0] xv, input logic [15:0] yv);
      wait_ready16();
      start16 = 1'b1; is16 = s; x16 = xv; y16 = yv;
      sb16.push_back('{ref_mul(16, s, 64'(xv), 64'(yv)), cyc + 1});
      @(negedge clk);
      start16 = 1'b0; is16 = 1'($urandom); x16 = 16'($urandom); y16 = 16'($urandom);
   endtask

   initial begin : stimulus
      int bc;
      repeat (2) @(negedge clk);
      check("rst_ready8", 64'(ready8), 64'd1);
      check("rst_busy8", 64'(busy8), 64'd0);
      check("rst_done8", 64'(done8), 64'd0);
      check("rst_prod8", 64'(prod8), 64'd0);
      check("rst_ready16", 64'(ready16), 64'd1);
      check("rst_prod16", 64'(prod16), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Extremes and signed corners
      go8(1'b0, 8'hFF, 8'hFF);
      go8(1'b0, 8'h00, 8'hAB);
      go8(1'b1, 8'h80, 8'h80);
      go8(1'b1, 8'hFF, 8'h7F);
      go8(1'b1, 8'h80, 8'h7F);

      // Busy rejection: a start pulse during RUN must be ignored
      go8(1'b0, 8'd3, 8'd5);
      bc = 1;
      start8 = 1'b1; x8 = 8'd9; y8 = 8'd9;
      @(negedge clk);
      start8 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!(busy8 && !ready8)) break;
         bc++;
         @(negedge clk);
      end
      check("busy_window8", 64'(bc), 64'd5);

      // Back-to-back: start held, second pair presented in the FIN cycle
      wait_ready8();
      repeat (2) @(negedge clk);
      start8 = 1'b1; is8 = 1'b0; x8 = 8'd3; y8 = 8'd5;
      sb8.push_back('{ref_mul(8, 1'b0, 64'd3, 64'd5), cyc + 1});
      @(negedge clk);
      wait_ready8();
      x8 = 8'd7; y8 = 8'd6;
      sb8.push_back('{ref_mul(8, 1'b0, 64'd7, 64'd6), cyc + 1});
      @(negedge clk);
      start8 = 1'b0;

      // Reset in the third RUN cycle aborts the operation
      go8(1'b0, 8'hFF, 8'hFF);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      sb8.delete();
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready8", 64'(ready8), 64'd1);
      check("abort_busy8", 64'(busy8), 64'd0);
      check("abort_prod8", 64'(prod8), 64'd0);
      repeat (10) @(negedge clk);
      go8(1'b0, 8'd2, 8'd3);

      for (int i = 0; i < 40; i++) begin
         go8(1'($urandom), 8'($urandom), 8'($urandom));
         repeat ($urandom_range(0, 7)) @(negedge clk);
      end

      // WIDTH=16 sweep
      go16(1'b0, 16'hFFFF, 16'hFFFF);
      go16(1'b1, 16'h8000, 16'h8000);
      go16(1'b1, 16'h8000, 16'h7FFF);
      for (int i = 0; i < 40; i++) begin
         go16(1'($urandom), 16'($urandom), 16'($urandom));
         repeat ($urandom_range(0, 11)) @(negedge clk);
      end

      for (int i = 0; i < 200 && (sb8.size() != 0 || sb16.size() != 0); i++) @(negedge clk);
      check("drain8", 64'(sb8.size()), 64'd0);
      check("drain16", 64'(sb16.size()), 64'd0);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
